// File: rtl/ha_serial_add_arbiter.sv
// Purpose: two-requester round-robin front end for a single bit-serial adder built from two half-adder cells.
// Latency: grant pulse 1 cycle after the request is sampled in IDLE, done pulse WIDTH+1 cycles after that sample.
// Backpressure: none queued; requests are sampled only in IDLE and ignored while busy.

module ha_serial_add_arbiter_ha (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module ha_serial_add_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             owner
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic [CW-1:0]    count;
    logic             c;
    logic             last;

    logic             p;
    logic             g1;
    logic             s;
    logic             g2;
    logic             c_next;
    logic [WIDTH-1:0] s_sr_next;
    logic             any_req;
    logic             win1;

    // Full adder for the current bit: operand half adder, then carry-in half adder.
    ha_serial_add_arbiter_ha u_ha1 (.x(a_sr[0]), .y(b_sr[0]), .s(p), .c(g1));
    ha_serial_add_arbiter_ha u_ha2 (.x(p),       .y(c),       .s(s), .c(g2));

    assign c_next    = g1 | g2;
    assign s_sr_next = (s_sr >> 1) | {s, {(WIDTH-1){1'b0}}};

    // Round robin: requester 1 wins when alone, or on a tie when requester 0 was served last.
    assign any_req = req0 | req1;
    assign win1    = req1 & (~req0 | ~last);

    assign busy = (state != IDLE);

    // Arbitration, operand capture, serial add and result publication.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            s_sr  <= '0;
            count <= '0;
            c     <= 1'b0;
            last  <= 1'b1;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            owner <= 1'b0;
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        a_sr  <= win1 ? a1 : a0;
                        b_sr  <= win1 ? b1 : b0;
                        s_sr  <= '0;
                        c     <= 1'b0;
                        count <= '0;
                        last  <= win1;
                        gnt0  <= ~win1;
                        gnt1  <= win1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    s_sr  <= s_sr_next;
                    c     <= c_next;
                    count <= count + 1'b1;
                    if (count == LAST_BIT) begin
                        sum   <= s_sr_next;
                        cout  <= c_next;
                        owner <= last;
                        done  <= 1'b1;
                        count <= '0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ha_serial_add_arbiter.sv
// Directed bench for the shared serial adder: reset, single adds, carry, fairness, late request, mid-op reset.
// Cycle k means the cycle after the k-th rising edge counted from the edge that samples the request.
// Inputs are driven 1 time unit after a rising edge; outputs are sampled at that same point.

module tb_ha_serial_add_arbiter;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0 = 1'b0;
    logic [W-1:0] a0 = '0;
    logic [W-1:0] b0 = '0;
    logic         req1 = 1'b0;
    logic [W-1:0] a1 = '0;
    logic [W-1:0] b1 = '0;
    logic         gnt0;
    logic         gnt1;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         owner;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    ha_serial_add_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
        .sum(sum), .cout(cout), .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    // Grants are mutually exclusive and never coincide with done.
    always @(negedge clk) begin
        if (rst_n) begin
            n_cmp++;
            assert (!(gnt0 && gnt1) && !(done && (gnt0 || gnt1))) else begin
                n_err++;
                $error("FAIL pulse_overlap: observed gnt0=%0b gnt1=%0b done=%0b expected no overlap", gnt0, gnt1, done);
            end
        end
    end

    initial begin
        // Reset: two cycles low, every output zero
        rst_n = 1'b0;
        tick(); tick();
        check("rst_gnt0", {31'd0, gnt0}, 32'd0);
        check("rst_gnt1", {31'd0, gnt1}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum", {24'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        check("rst_owner", {31'd0, owner}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("rel_busy", {31'd0, busy}, 32'd0);

        // Single add on requester 0: 0x5A + 0x33 = 0x8D
        req0 = 1'b1; a0 = 8'h5A; b0 = 8'h33; cyc = 0;
        tick();
        check("single_gnt0", {31'd0, gnt0}, 32'd1);
        check("single_busy", {31'd0, busy}, 32'd1);
        req0 = 1'b0; a0 = '0; b0 = '0;
        tick();
        check("single_gnt0_pulse", {31'd0, gnt0}, 32'd0);
        run_to(8);
        check("single_no_early_done", {31'd0, done}, 32'd0);
        check("single_no_partial_sum", {24'd0, sum}, 32'd0);
        tick();
        check("single_done", {31'd0, done}, 32'd1);
        check("single_sum", {24'd0, sum}, 32'h8D);
        check("single_cout", {31'd0, cout}, 32'd0);
        check("single_owner", {31'd0, owner}, 32'd0);
        tick();
        check("single_done_pulse", {31'd0, done}, 32'd0);
        check("single_idle", {31'd0, busy}, 32'd0);
        check("single_hold_sum", {24'd0, sum}, 32'h8D);

        // Carry ripple on requester 1: 0xFF + 0x01 = 0x100
        req1 = 1'b1; a1 = 8'hFF; b1 = 8'h01; cyc = 0;
        tick();
        check("ripple_gnt1", {31'd0, gnt1}, 32'd1);
        req1 = 1'b0;
        run_to(9);
        check("ripple_done", {31'd0, done}, 32'd1);
        check("ripple_sum", {24'd0, sum}, 32'h00);
        check("ripple_cout", {31'd0, cout}, 32'd1);
        check("ripple_owner", {31'd0, owner}, 32'd1);
        tick();

        // Full scale on requester 0: 0xFF + 0xFF = 0x1FE
        req0 = 1'b1; a0 = 8'hFF; b0 = 8'hFF; cyc = 0;
        tick();
        check("full_gnt0", {31'd0, gnt0}, 32'd1);
        req0 = 1'b0;
        run_to(9);
        check("full_done", {31'd0, done}, 32'd1);
        check("full_sum", {24'd0, sum}, 32'hFE);
        check("full_cout", {31'd0, cout}, 32'd1);
        check("full_owner", {31'd0, owner}, 32'd0);
        tick();

        // Late request: req1 rises in cycle 3 of a requester 0 add
        req0 = 1'b1; a0 = 8'h12; b0 = 8'h34; cyc = 0;
        tick();
        check("late_gnt0", {31'd0, gnt0}, 32'd1);
        req0 = 1'b0;
        run_to(3);
        req1 = 1'b1; a1 = 8'h01; b1 = 8'h02;
        run_to(9);
        check("late_done0", {31'd0, done}, 32'd1);
        check("late_sum0", {24'd0, sum}, 32'h46);
        check("late_no_gnt1_at_done", {31'd0, gnt1}, 32'd0);
        tick();
        check("late_no_gnt1_idle", {31'd0, gnt1}, 32'd0);
        check("late_idle", {31'd0, busy}, 32'd0);
        tick();
        check("late_gnt1_c11", {31'd0, gnt1}, 32'd1);
        req1 = 1'b0;
        run_to(19);
        check("late_done1", {31'd0, done}, 32'd1);
        check("late_sum1", {24'd0, sum}, 32'h03);
        check("late_owner1", {31'd0, owner}, 32'd1);
        tick();

        // Tie and fairness: both requests held from reset release
        rst_n = 1'b0;
        req0 = 1'b1; a0 = 8'h01; b0 = 8'h02;
        req1 = 1'b1; a1 = 8'h40; b1 = 8'h05;
        tick(); tick();
        rst_n = 1'b1; cyc = 0;
        for (int k = 0; k < 4; k++) begin
            run_to(1 + 10 * k);
            check("tie_gnt0", {31'd0, gnt0}, (k % 2 == 0) ? 32'd1 : 32'd0);
            check("tie_gnt1", {31'd0, gnt1}, (k % 2 == 1) ? 32'd1 : 32'd0);
            run_to(9 + 10 * k);
            check("tie_done", {31'd0, done}, 32'd1);
            check("tie_owner", {31'd0, owner}, (k % 2 == 1) ? 32'd1 : 32'd0);
            check("tie_sum", {24'd0, sum}, (k % 2 == 1) ? 32'h45 : 32'h03);
        end
        req0 = 1'b0; req1 = 1'b0;
        run_to(41);

        // Mid-operation reset in SHIFT cycle 4
        req0 = 1'b1; a0 = 8'h77; b0 = 8'h11; cyc = 0;
        tick();
        check("mid_gnt0", {31'd0, gnt0}, 32'd1);
        req0 = 1'b0;
        run_to(4);
        rst_n = 1'b0;
        tick();
        check("mid_busy", {31'd0, busy}, 32'd0);
        check("mid_done", {31'd0, done}, 32'd0);
        check("mid_sum", {24'd0, sum}, 32'd0);
        check("mid_cout", {31'd0, cout}, 32'd0);
        check("mid_owner", {31'd0, owner}, 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("mid_no_done", {31'd0, done}, 32'd0);
        end
        req0 = 1'b1; a0 = 8'h10; b0 = 8'h20; cyc = 0;
        tick();
        check("post_gnt0", {31'd0, gnt0}, 32'd1);
        req0 = 1'b0;
        run_to(9);
        check("post_done", {31'd0, done}, 32'd1);
        check("post_sum", {24'd0, sum}, 32'h30);
        check("post_cout", {31'd0, cout}, 32'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ha_serial_add_arbiter.md
Name: ha_serial_add_arbiter

Overview:
- Shares one bit-serial add engine between two requesters.
- The engine is a full-adder cell built from two half-adder cells plus an OR, with a carry flop.
- A round-robin arbiter grants one requester at a time. The block captures that requester's operands, adds them LSB-first over WIDTH cycles, then returns a tagged result with a done pulse.
- It sits between client datapaths and the single shared adder cell, trading latency for area.

Parameters:
- WIDTH, default 8: operand width in bits; must be ≥ 2.

Ports:
- clk  input  1  system clock; rising-edge active.
- rst_n  input  1  synchronous, active-low reset.
- req0  input  1  requester 0 request.
- a0  input  WIDTH  requester 0 operand A.
- b0  input  WIDTH  requester 0 operand B.
- req1  input  1  requester 1 request.
- a1  input  WIDTH  requester 1 operand A.
- b1  input  WIDTH  requester 1 operand B.
- gnt0  output  1  one-cycle pulse: requester 0 operands captured.
- gnt1  output  1  one-cycle pulse: requester 1 operands captured.
- busy  output  1  high when state is not IDLE.
- done  output  1  one-cycle pulse: sum, cout and owner hold a new result.
- sum  output  WIDTH  last completed sum, low WIDTH bits.
- cout  output  1  last completed carry-out.
- owner  output  1  requester index of the last completed result.

Behaviour:
- Clock and reset: single clock domain (clk). rst_n is synchronous and active-low, sampled on the rising edge of clk.
- Reset values:
  - state = IDLE.
  - gnt0, gnt1, busy, done = 0.
  - sum = 0, cout = 0, owner = 0.
  - Carry, count and shift registers = 0.
  - Round-robin pointer last = 1, so req0 wins the first tie.
- IDLE:
  - req0/req1 are sampled only in IDLE.
  - Only one request high: grant it.
  - Both high: grant the requester that is not last.
  - On the granting edge: load a_sr/b_sr from the winner, clear carry and count, set last = winner, go to SHIFT.
  - The matching gntX is registered: high exactly one cycle, the first SHIFT cycle.
- SHIFT, one bit per cycle:
  - HA1: p = a_sr[0]^b_sr[0], g1 = a_sr[0]&b_sr[0].
  - HA2: s = p^c, g2 = p&c.
  - c <= g1|g2.
  - s_sr <= {s, s_sr[WIDTH-1:1]}.
  - a_sr and b_sr shift right by 1; count increments.
  - The edge that processes bit WIDTH-1 moves to DONE and copies the final s_sr, final carry and last into sum, cout and owner.
- DONE: done = 1 for one cycle, then IDLE.
- Timing: request sampled at edge 0 → gnt high in cycle 1 → SHIFT in cycles 1..WIDTH → done high in cycle WIDTH+1 → IDLE in cycle WIDTH+2. Throughput is one add per WIDTH+2 cycles.
- Requester protocol:
  - Hold reqX and operands stable until gntX is seen; the block captures them on the granting edge.
  - A req still high when the block next reaches IDLE is a new request.
- Outputs between operations:
  - sum, cout and owner change only on entry to DONE.
  - They hold the last result indefinitely and never show partial values.
- Boundary conditions:
  - Requests arriving while busy are ignored until IDLE; no queueing.
  - If both requesters hold req continuously, grants alternate 0,1,0,1…
  - Full-scale operands wrap modulo 2^WIDTH with cout = 1 (e.g. 0xFF + 0xFF → sum 0xFE, cout 1).
  - Reset mid-operation: abort without a done pulse and restore all reset values, including sum = 0.
- busy is combinational from state and is high in SHIFT and DONE.
- gnt0 and gnt1 are never high together; done is never high in the same cycle as any gnt.

Test Plan:
- Reset (WIDTH=8): hold rst_n = 0 for 2 cycles → every output 0; busy 0 after release.
- Single add: req0 = 1, a0 = 0x5A, b0 = 0x33 in IDLE → gnt0 in cycle 1; done in cycle 9 with sum = 0x8D, cout = 0, owner = 0.
- Carry ripple: req1, a1 = 0xFF, b1 = 0x01 → done after 9 cycles with sum = 0x00, cout = 1, owner = 1.
- Tie and fairness: req0 and req1 both held high from reset release → grant order 0,1,0,1; each done spaced 10 cycles apart.
- Late request: req1 raised in cycle 3 of a req0 operation → no gnt1 until after done; gnt1 first seen in cycle 11.
- Mid-operation reset: rst_n = 0 during SHIFT cycle 4 → no done pulse; sum, cout, busy all 0; a subsequent req0 with 0x10 + 0x20 completes with sum = 0x30.
